// File: rtl/baser_257b_transcoder.sv
// Transmit-side 256b/257b transcoder: packs four sanitised 66b BASE-R
// blocks into one 257b block behind a single-entry output hold register.
module baser_257b_transcoder #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          SH_WIDTH_IN       = 2,
  parameter int          TC_WIDTH          = 257,
  parameter logic [6:0]  CTRL_CHAR_PATTERN = 7'h1E
) (
  input  logic                                clk,
  input  logic                                i_rst,
  input  logic [DATA_WIDTH+SH_WIDTH_IN-1:0]   i_block,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic                                i_clear,
  output logic [TC_WIDTH-1:0]                 o_tc_data,
  output logic                                o_tc_valid,
  input  logic                                i_tc_ready,
  output logic [31:0]                         o_tc_count,
  output logic [31:0]                         o_err_count
);

  localparam int BW = DATA_WIDTH + SH_WIDTH_IN;

  logic [1:0]                  gcnt_q, gcnt_d;
  logic [2:0][DATA_WIDTH-1:0]  pay_q, pay_d;
  logic [2:0]                  flg_q, flg_d;
  logic [TC_WIDTH-1:0]         tc_q, tc_d;
  logic                        tcv_q, tcv_d;
  logic [31:0]                 tcc_q, tcc_d;
  logic [31:0]                 errc_q, errc_d;

  logic [SH_WIDTH_IN-1:0]      sh;
  logic [DATA_WIDTH-1:0]       raw;
  logic                        type_ok;
  logic                        is_data;
  logic                        bad;
  logic [DATA_WIDTH-1:0]       san_pay;
  logic                        accept;
  logic                        last;
  logic                        load;
  logic                        hs;
  logic [3:0][DATA_WIDTH-1:0]  blk;
  logic [3:0]                  flg;
  logic [TC_WIDTH-1:0]         tc_comb;

  assign sh  = i_block[SH_WIDTH_IN-1:0];
  assign raw = i_block[BW-1:SH_WIDTH_IN];

  // Recognise the legal control block type bytes
  always_comb begin
    type_ok = 1'b0;
    case (raw[7:0])
      8'h1E, 8'h78, 8'h4B, 8'h87,
      8'h99, 8'hAA, 8'hB4, 8'hCC,
      8'hD2, 8'hE1, 8'hFF: type_ok = 1'b1;
      default:             type_ok = 1'b0;
    endcase
  end

  // Sanitise the incoming block; anything illegal becomes an error ctrl block
  always_comb begin
    is_data = (sh == 2'b01);
    bad     = !is_data && !((sh == 2'b10) && type_ok);
    san_pay = raw;
    if (bad) san_pay = {{8{CTRL_CHAR_PATTERN}}, 8'h1E};
  end

  assign last    = (gcnt_q == 2'd3);
  assign o_ready = !(last && tcv_q && !i_tc_ready);
  assign accept  = i_valid && o_ready;
  assign load    = accept && last && !i_clear;
  assign hs      = tcv_q && i_tc_ready;

  assign blk = {san_pay, pay_q};
  assign flg = {is_data, flg_q};

  // Pack the three buffered blocks and the current one into 257 bits
  always_comb begin
    logic seen;
    tc_comb = '0;
    seen    = 1'b0;
    if (&flg) begin
      tc_comb[0] = 1'b1;
      for (int i = 0; i < 4; i++)
        tc_comb[64*i+1 +: 64] = blk[i];
    end else begin
      tc_comb[4:1] = flg;
      for (int i = 0; i < 4; i++) begin
        if (seen) begin
          tc_comb[64*i+1 +: 64] = blk[i];
        end else if (flg[i]) begin
          tc_comb[64*i+5 +: 64] = blk[i];
        end else begin
          tc_comb[64*i+5 +: 4]  = blk[i][7:4];
          tc_comb[64*i+9 +: 56] = blk[i][63:8];
          seen = 1'b1;
        end
      end
    end
  end

  // Group counter and buffer; a clear restarts the group at block 0
  always_comb begin
    logic [1:0] idx;
    gcnt_d = gcnt_q;
    pay_d  = pay_q;
    flg_d  = flg_q;
    idx    = i_clear ? 2'd0 : gcnt_q;
    if (i_clear)
      gcnt_d = accept ? 2'd1 : 2'd0;
    else if (accept)
      gcnt_d = gcnt_q + 2'd1;
    if (accept && (i_clear || !last)) begin
      for (int k = 0; k < 3; k++) begin
        if (idx == k[1:0]) begin
          pay_d[k] = san_pay;
          flg_d[k] = is_data;
        end
      end
    end
  end

  // Output hold register and the two statistics counters
  always_comb begin
    tc_d   = tc_q;
    tcv_d  = tcv_q;
    tcc_d  = tcc_q;
    errc_d = errc_q;
    if (hs) begin
      tcv_d = 1'b0;
      tcc_d = tcc_q + 32'd1;
    end
    if (load) begin
      tc_d  = tc_comb;
      tcv_d = 1'b1;
    end
    if (accept && bad && (errc_q != 32'hFFFF_FFFF))
      errc_d = errc_q + 32'd1;
  end

  // State registers
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      gcnt_q <= '0;
      pay_q  <= '0;
      flg_q  <= '0;
      tc_q   <= '0;
      tcv_q  <= 1'b0;
      tcc_q  <= '0;
      errc_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      pay_q  <= pay_d;
      flg_q  <= flg_d;
      tc_q   <= tc_d;
      tcv_q  <= tcv_d;
      tcc_q  <= tcc_d;
      errc_q <= errc_d;
    end
  end

  assign o_tc_data   = tc_q;
  assign o_tc_valid  = tcv_q;
  assign o_tc_count  = tcc_q;
  assign o_err_count = errc_q;

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Bench for baser_257b_transcoder: directed cases plus a random stream
// checked against a bit-appending reference model.
module tb_baser_257b_transcoder;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [65:0]  i_block;
  logic         i_valid;
  logic         o_ready;
  logic         i_clear;
  logic [256:0] o_tc_data;
  logic         o_tc_valid;
  logic         i_tc_ready;
  logic [31:0]  o_tc_count;
  logic [31:0]  o_err_count;

  baser_257b_transcoder dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_block     (i_block),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_clear     (i_clear),
    .o_tc_data   (o_tc_data),
    .o_tc_valid  (o_tc_valid),
    .i_tc_ready  (i_tc_ready),
    .o_tc_count  (o_tc_count),
    .o_err_count (o_err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] vt [0:10] = '{8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA,
                            8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  logic [63:0]  gp [$];
  bit           gf [$];
  logic [65:0]  sq [$];
  bit           m_valid;
  logic [256:0] m_data;
  logic [31:0]  m_tcc;
  logic [31:0]  m_errc;

  localparam logic [63:0] AA  = {8{8'hAA}};
  localparam logic [63:0] C1E = {{8{7'h1E}}, 8'h1E};

  task automatic chk(input string tag, input logic [256:0] obs,
                     input logic [256:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic void san(input logic [65:0] b, output logic [63:0] p,
                              output bit f, output bit bad);
    bit ok = 0;
    p = b[65:2];
    f = (b[1:0] == 2'b01);
    if (b[1:0] == 2'b10)
      for (int k = 0; k < 11; k++) if (p[7:0] == vt[k]) ok = 1;
    bad = !f && !ok;
    if (bad) p = C1E;
  endfunction

  // Reference: the 257b block as a stream of appended bits, LSB first
  function automatic logic [256:0] ref4(input logic [63:0] p0, p1, p2, p3,
                                        input bit [3:0] f);
    logic [63:0]  p [4];
    logic [256:0] r = '0;
    int           pos = 1;
    bit           first = 1;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    if (f == 4'hF) begin
      r[0] = 1'b1;
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 64; k++) r[pos++] = p[i][k];
    end else begin
      for (int i = 0; i < 4; i++) r[pos++] = f[i];
      for (int i = 0; i < 4; i++) begin
        if (!f[i] && first) begin
          for (int k = 4; k < 64; k++) r[pos++] = p[i][k];
          first = 0;
        end else begin
          for (int k = 0; k < 64; k++) r[pos++] = p[i][k];
        end
      end
    end
    return r;
  endfunction

  task automatic cyc(input bit v, input logic [65:0] b, input bit clr,
                     input bit rdy, output bit acc);
    logic [63:0] p;
    bit f, bad, mr;
    bit [3:0] ff;
    i_valid = v; i_block = b; i_clear = clr; i_tc_ready = rdy;
    @(negedge clk);
    mr = !(gp.size() == 3 && m_valid && !rdy);
    chk("o_ready", o_ready, mr);
    chk("o_tc_valid", o_tc_valid, m_valid);
    if (m_valid) chk("o_tc_data", o_tc_data, m_data);
    chk("o_tc_count", o_tc_count, m_tcc);
    chk("o_err_count", o_err_count, m_errc);
    acc = v && mr;
    if (m_valid && rdy) begin
      m_tcc++;
      m_valid = 0;
    end
    if (clr) begin
      gp.delete();
      gf.delete();
    end
    if (acc) begin
      san(b, p, f, bad);
      if (bad && m_errc != 32'hFFFF_FFFF) m_errc++;
      if (gp.size() == 3) begin
        ff = {f, gf[2], gf[1], gf[0]};
        m_data  = ref4(gp[0], gp[1], gp[2], p, ff);
        m_valid = 1;
        gp.delete();
        gf.delete();
      end else begin
        gp.push_back(p);
        gf.push_back(f);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic stream(input int hold);
    int c = 0;
    bit acc;
    while (sq.size() > 0 && c < 200) begin
      cyc(1'b1, sq[0], 1'b0, c >= hold, acc);
      if (acc) void'(sq.pop_front());
      c++;
    end
    n_chk++;
    if (sq.size() > 0) begin
      n_err++;
      $error("FAIL stream_timeout obs=%0d exp=0", sq.size());
      sq.delete();
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset();
    i_valid = 0; i_clear = 0; i_rst = 1;
    #2;
    gp.delete(); gf.delete();
    m_valid = 0; m_data = '0; m_tcc = '0; m_errc = '0;
    chk("rst_valid", o_tc_valid, 1'b0);
    chk("rst_data", o_tc_data, '0);
    chk("rst_tcc", o_tc_count, '0);
    chk("rst_errc", o_err_count, '0);
    @(posedge clk); #1;
    i_rst = 0;
  endtask

  function automatic logic [65:0] rnd_blk();
    logic [63:0] p = {$urandom, $urandom};
    int r = $urandom_range(0, 99);
    if (r < 45) return {p, 2'b01};
    if (r < 90) begin
      p[7:0] = vt[$urandom_range(0, 10)];
      return {p, 2'b10};
    end
    if (r < 95) return {p, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00};
    return {p, 2'b10};
  endfunction

  initial begin
    bit acc;
    logic [31:0] e0;
    i_block = '0; i_valid = 0; i_clear = 0; i_tc_ready = 1; i_rst = 1;
    @(posedge clk); #1;
    do_reset();
    chk("rst_ready", o_ready, 1'b1);

    // all data
    repeat (4) sq.push_back({AA, 2'b01});
    stream(0);
    chk("t1_valid", o_tc_valid, 1'b1);
    chk("t1_lit", o_tc_data, {{32{8'hAA}}, 1'b1});
    idle(2);

    // all ctrl 1E
    repeat (4) sq.push_back({C1E, 2'b10});
    stream(0);
    chk("t2_lit", o_tc_data,
        {C1E, C1E, C1E, {8{7'h1E}}, 4'h1, 4'b0000, 1'b0});
    chk("t2_errc", o_err_count, 32'd0);
    idle(2);

    // D D S D
    sq.push_back({AA, 2'b01});
    sq.push_back({AA, 2'b01});
    sq.push_back({{7{8'hAA}}, 8'h78, 2'b10});
    sq.push_back({AA, 2'b01});
    stream(0);
    chk("t3_lit", o_tc_data,
        {AA, {7{8'hAA}}, 4'h7, AA, AA, 4'b1011, 1'b0});
    idle(2);

    // bad header on block 1
    e0 = o_err_count;
    sq.push_back({AA, 2'b01});
    sq.push_back({AA, 2'b11});
    sq.push_back({AA, 2'b01});
    sq.push_back({AA, 2'b01});
    stream(0);
    chk("t4_f", o_tc_data[4:1], 4'b1101);
    chk("t4_type", o_tc_data[72:69], 4'h1);
    chk("t4_errc", o_err_count, e0 + 32'd1);
    idle(2);

    // backpressure for 10 cycles over 8 blocks
    e0 = o_tc_count;
    for (int i = 0; i < 8; i++) sq.push_back({64'(i) * 64'h0101_0101_0101_0101 + 64'h1234, 2'b01});
    stream(10);
    idle(4);
    chk("t5_tcc", o_tc_count, e0 + 32'd2);

    // clear with acceptance, then clear on 4th block
    e0 = o_tc_count;
    repeat (2) sq.push_back({AA, 2'b01});
    stream(0);
    cyc(1'b1, {64'h5555_0000_1111_2222, 2'b01}, 1'b1, 1'b1, acc);
    repeat (3) sq.push_back({64'h0F0F_0F0F_0F0F_0F0F, 2'b01});
    stream(0);
    idle(2);
    chk("t6_tcc", o_tc_count, e0 + 32'd1);
    repeat (3) sq.push_back({AA, 2'b01});
    stream(0);
    cyc(1'b1, {AA, 2'b01}, 1'b1, 1'b1, acc);
    idle(3);
    chk("t7_tcc", o_tc_count, e0 + 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b1, acc);

    // reset mid-group
    repeat (2) sq.push_back({64'hDEAD_BEEF_0000_0001, 2'b01});
    stream(0);
    do_reset();
    for (int i = 0; i < 4; i++) sq.push_back({64'(i + 7) * 64'h1111, 2'b01});
    stream(0);
    idle(2);
    chk("t8_tcc", o_tc_count, 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 7, rnd_blk(), $urandom_range(0, 99) < 3,
          $urandom_range(0, 9) < 7, acc);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
